// File: rtl/tx_framer.sv
// tx_framer: word/PRBS serialiser producing start/data/parity/stop
// frames on a single-bit optical line, one bit per clk_bit cycle.
module tx_framer #(
    parameter int DATA_W   = 8,
    parameter int PARITY   = 0,
    parameter int PRBS_N   = 7,
    parameter int PRBS_TAP = 6
) (
    input  logic              clk_bit,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              prbs_on,
    input  logic              err_inject,
    output logic              out,
    output logic              nextword_enable
);

    localparam int FRAME_LEN = DATA_W + 2 + ((PARITY != 0) ? 1 : 0);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]     cnt;
    logic [PRBS_N-1:0]    lfsr;
    logic [PRBS_N-1:0]    lfsr_next;
    logic [FRAME_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] frame;
    logic [DATA_W-1:0]    prbs_word;
    logic [DATA_W-1:0]    payload;
    logic [DATA_W-1:0]    sent;
    logic                 load;
    logic                 idle;
    logic                 par;

    assign load            = (cnt == LAST) && !rst;
    assign nextword_enable = load;
    assign d_ready         = load && !prbs_on;

    // Run the LFSR DATA_W steps ahead; the word is used only on a PRBS load
    always_comb begin
        lfsr_next = lfsr;
        prbs_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            prbs_word[i] = lfsr_next[PRBS_N-1] ^ lfsr_next[PRBS_TAP-1];
            lfsr_next    = {lfsr_next[PRBS_N-2:0], prbs_word[i]};
        end
    end

    // Assemble the next frame: idle is all ones, else start/data/parity/stop
    always_comb begin
        payload = prbs_on ? prbs_word : d_in;
        idle    = !prbs_on && !d_valid;
        sent    = payload;
        if (err_inject)
            sent[0] = ~payload[0];
        par   = (^payload) ^ (PARITY == 2);
        frame = '1;
        if (!idle) begin
            frame[0]        = 1'b0;
            frame[DATA_W:1] = sent;
            if (PARITY != 0)
                frame[DATA_W+1] = par;
        end
    end

    // Bit counter, shift register, line register and LFSR state
    always_ff @(posedge clk_bit) begin
        if (rst) begin
            out   <= 1'b1;
            cnt   <= LAST;
            lfsr  <= '1;
            shreg <= '1;
        end else if (load) begin
            cnt   <= '0;
            out   <= frame[0];
            shreg <= {1'b1, frame[FRAME_LEN-1:1]};
            if (prbs_on)
                lfsr <= lfsr_next;
        end else begin
            cnt   <= cnt + 1'b1;
            out   <= shreg[0];
            shreg <= {1'b1, shreg[FRAME_LEN-1:1]};
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: three framers (no/even/odd parity) on shared stimulus,
// each checked every cycle against a queue-based line model.
module tb_tx_framer;

    logic       clk_bit = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_in = 8'hA5;
    logic       d_valid = 1'b1;
    logic       prbs_on = 1'b0;
    logic       err_inject = 1'b0;
    logic [2:0] out_w;
    logic [2:0] rdy_w;
    logic [2:0] nwe_w;
    bit         armed = 1'b0;
    int         errors = 0;
    int         checks = 0;

    // Free-running bit clock
    initial forever #5 clk_bit = ~clk_bit;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int PAR = g;
        localparam int FL  = 10 + ((g != 0) ? 1 : 0);
        logic o;
        logic r;
        logic n;

        tx_framer #(
            .DATA_W(8), .PARITY(PAR), .PRBS_N(7), .PRBS_TAP(6)
        ) dut (
            .clk_bit(clk_bit), .rst(rst), .d_in(d_in), .d_valid(d_valid),
            .d_ready(r), .prbs_on(prbs_on), .err_inject(err_inject),
            .out(o), .nextword_enable(n)
        );

        assign out_w[g] = o;
        assign rdy_w[g] = r;
        assign nwe_w[g] = n;

        bit        q[$];
        bit [6:0]  lf;
        bit [7:0]  pl;
        bit [10:0] fb;
        bit        nb;
        bit        exp_out;

        // Line model: queue of bits still to show; empty queue = load cycle
        always @(posedge clk_bit) begin
            if (rst) begin
                q.delete();
                lf      = 7'h7f;
                exp_out = 1'b1;
            end else if (q.size() == 0) begin
                fb = '1;
                if (prbs_on || d_valid) begin
                    if (prbs_on) begin
                        for (int i = 0; i < 8; i++) begin
                            nb    = lf[6] ^ lf[5];
                            lf    = {lf[5:0], nb};
                            pl[i] = nb;
                        end
                    end else begin
                        pl = d_in;
                    end
                    fb[0] = 1'b0;
                    for (int i = 0; i < 8; i++)
                        fb[i+1] = pl[i] ^ ((i == 0) && err_inject);
                    if (PAR != 0)
                        fb[9] = (^pl) ^ (PAR == 2);
                end
                exp_out = fb[0];
                for (int i = 1; i < FL; i++)
                    q.push_back(fb[i]);
            end else begin
                exp_out = q.pop_front();
            end
        end

        // Per-cycle comparison of line and strobes against the model
        always @(negedge clk_bit) begin
            if (armed) begin
                chk($sformatf("u%0d_out", g), 32'(o), 32'(exp_out));
                chk($sformatf("u%0d_ready", g), 32'(r),
                    32'(!rst && q.size() == 0 && !prbs_on));
                chk($sformatf("u%0d_nwe", g), 32'(n),
                    32'(!rst && q.size() == 0));
            end
        end
    end

    task automatic step();
        @(posedge clk_bit);
        #1;
    endtask

    task automatic cap(output logic [10:0] b0, output logic [10:0] b1,
                       output logic [10:0] b2);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_bit);
            b0[i] = out_w[0];
            b1[i] = out_w[1];
            b2[i] = out_w[2];
        end
    endtask

    task automatic wait_load();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_bit);
            seen = (nwe_w[0] === 1'b1);
        end
        chk("load_timeout", 32'(seen), 32'd1);
    endtask

    logic [10:0] b0;
    logic [10:0] b1;
    logic [10:0] b2;
    int          ones;
    int          rdys;

    // Directed scenarios followed by randomized traffic
    initial begin
        step();
        step();
        armed = 1'b1;
        @(negedge clk_bit);
        chk("rst_out", 32'(out_w), 32'h7);
        chk("rst_ready", 32'(rdy_w), 32'h0);
        chk("rst_nwe", 32'(nwe_w), 32'h0);

        step();
        rst = 1'b0;
        @(negedge clk_bit);
        chk("a5_nwe", 32'(nwe_w[0]), 32'd1);
        chk("a5_ready", 32'(rdy_w[0]), 32'd1);
        cap(b0, b1, b2);
        chk("a5_nopar", 32'(b0[9:0]), 32'(10'b1101001010));
        chk("a5_even", 32'(b1), 32'(11'b10101001010));
        chk("a5_odd", 32'(b2), 32'(11'b11101001010));

        step();
        rst = 1'b1;
        d_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        ones = 0;
        rdys = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_bit);
            ones += int'(out_w[0]);
            rdys += int'(rdy_w[0]);
        end
        chk("idle_ones", 32'(ones), 32'd20);
        chk("idle_ready", 32'(rdys), 32'd2);
        step();
        d_valid = 1'b1;
        d_in = 8'($urandom);
        repeat (30) step();

        rst = 1'b1;
        prbs_on = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk_bit);
        chk("prbs_ready", 32'(rdy_w[0]), 32'd0);
        chk("prbs_nwe", 32'(nwe_w[0]), 32'd1);
        cap(b0, b1, b2);
        chk("prbs_first", 32'(b0[9:0]), 32'(10'b1010000000));
        repeat (600) step();
        wait_load();
        repeat (10) step();
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        repeat (2000) step();

        wait_load();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk_bit);
        chk("mid_rst_out", 32'(out_w[0]), 32'd1);
        chk("mid_rst_nwe", 32'(nwe_w[0]), 32'd1);
        cap(b0, b1, b2);
        chk("mid_rst_prbs", 32'(b0[9:0]), 32'(10'b1010000000));

        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0)
                prbs_on = ~prbs_on;
            d_valid = ($urandom_range(0, 3) != 0);
            d_in = 8'($urandom);
            err_inject = ($urandom_range(0, 7) == 0);
        end
        step();
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
